// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard/stall controller
package hazard_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        HALT     = 2'b10
    } hz_state_e;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - pipeline-side hazard inputs and pipeline control enables
interface hazard_stall_unit_if;
    import hazard_pkg::*;

    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic                 id_uses_rs1;
    logic                 id_uses_rs2;
    logic [REG_IDX_W-1:0] idex_rd;
    logic                 idex_is_load;
    logic                 ex_branch_taken;
    logic                 mem_req;
    logic                 mem_ready;

    logic                 pc_write;
    logic                 ifid_write;
    logic                 ifid_flush;
    logic                 idex_bubble;
    logic                 pipe_freeze;

    // The pipeline datapath reports hazard sources and obeys the enables.
    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, idex_rd, idex_is_load,
               ex_branch_taken, mem_req, mem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, idex_rd, idex_is_load,
               ex_branch_taken, mem_req, mem_ready,
        output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze
    );

endinterface

// File: rtl/hazard_stall_unit_load_use_detect.sv
// rtl/hazard_stall_unit_load_use_detect.sv - combinational load-use dependency comparator
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [REG_IDX_W-1:0] idex_rd,
    input  logic                 idex_is_load,
    output logic                 load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_uses_rs1 && (id_rs1 == idex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == idex_rd);
    // x0 is hardwired to zero, so a load targeting it never produces a dependency.
    assign load_use = idex_is_load && (idex_rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - interlock controller: load-use bubbles, memory-wait freeze,
// branch flush, memory-timeout halt, and a saturating stall-cycle counter
module hazard_stall_unit #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    hazard_stall_unit_if.slave pipe,
    output logic             mem_timeout,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cycles
);
    import hazard_pkg::*;

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    hz_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              timeout_q, timeout_d;

    logic load_use;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze;

    load_use_detect u_load_use_detect (
        .id_rs1       (pipe.id_rs1),
        .id_rs2       (pipe.id_rs2),
        .id_uses_rs1  (pipe.id_uses_rs1),
        .id_uses_rs2  (pipe.id_uses_rs2),
        .idex_rd      (pipe.idex_rd),
        .idex_is_load (pipe.idex_is_load),
        .load_use     (load_use)
    );

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;

        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (pipe.mem_req && !pipe.mem_ready) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        pipe_freeze = 1'b1;
                        state_d     = MEM_WAIT;
                        wait_cnt_d  = WAIT_ONE;
                    end else if (pipe.ex_branch_taken) begin
                        // The ID instruction is wrong-path, so any load-use on it is moot.
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!pipe.mem_ready) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        pipe_freeze = 1'b1;
                        if (wait_cnt_q == WAIT_MAX) begin
                            state_d   = HALT;
                            timeout_d = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WAIT_ONE;
                        end
                    end else begin
                        // Release cycle: the ID-stage hazards still apply to this cycle.
                        state_d    = RUN;
                        wait_cnt_d = '0;
                        if (pipe.ex_branch_taken) begin
                            ifid_flush  = 1'b1;
                            idex_bubble = 1'b1;
                        end else if (load_use) begin
                            pc_write    = 1'b0;
                            ifid_write  = 1'b0;
                            idex_bubble = 1'b1;
                        end
                    end
                end
                HALT: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    pipe_freeze = 1'b1;
                end
                default: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    pipe_freeze = 1'b1;
                    state_d     = RUN;
                    wait_cnt_d  = '0;
                end
            endcase
        end

        stall_d = stall_q;
        if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            stall_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
            timeout_q  <= timeout_d;
        end
    end

    assign pipe.pc_write    = pc_write;
    assign pipe.ifid_write  = ifid_write;
    assign pipe.ifid_flush  = ifid_flush;
    assign pipe.idex_bubble = idex_bubble;
    assign pipe.pipe_freeze = pipe_freeze;
    assign mem_timeout      = timeout_q;
    assign hz_state         = state_q;
    assign stall_cycles     = stall_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed self-checking bench for hazard_stall_unit
module tb_hazard_stall_unit;

    logic       clk;
    logic       reset;
    logic       mem_timeout;
    logic [1:0] hz_state;
    logic [3:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    hazard_stall_unit_if hif ();

    hazard_stall_unit #(
        .MAX_WAIT (4),
        .CNT_W    (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pipe         (hif),
        .mem_timeout  (mem_timeout),
        .hz_state     (hz_state),
        .stall_cycles (stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hif.id_rs1          = 5'd0;
        hif.id_rs2          = 5'd0;
        hif.id_uses_rs1     = 1'b0;
        hif.id_uses_rs2     = 1'b0;
        hif.idex_rd         = 5'd0;
        hif.idex_is_load    = 1'b0;
        hif.ex_branch_taken = 1'b0;
        hif.mem_req         = 1'b0;
        hif.mem_ready       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (hif.pc_write !== 1'b0) begin failures++; $display("FAIL rst_pc_write got=%0b exp=0", hif.pc_write); end
        checks++; if (hif.ifid_write !== 1'b0) begin failures++; $display("FAIL rst_ifid_write got=%0b exp=0", hif.ifid_write); end
        checks++; if (hif.ifid_flush !== 1'b1) begin failures++; $display("FAIL rst_ifid_flush got=%0b exp=1", hif.ifid_flush); end
        checks++; if (hif.idex_bubble !== 1'b1) begin failures++; $display("FAIL rst_idex_bubble got=%0b exp=1", hif.idex_bubble); end
        checks++; if (hif.pipe_freeze !== 1'b0) begin failures++; $display("FAIL rst_pipe_freeze got=%0b exp=0", hif.pipe_freeze); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (hz_state !== 2'b00) begin failures++; $display("FAIL rst_state got=%0d exp=0", hz_state); end
        checks++; if (stall_cycles !== 4'd0) begin failures++; $display("FAIL rst_stall got=%0d exp=0", stall_cycles); end
        checks++; if (mem_timeout !== 1'b0) begin failures++; $display("FAIL rst_timeout got=%0b exp=0", mem_timeout); end
        checks++; if (hif.pc_write !== 1'b1 || hif.ifid_flush !== 1'b0) begin failures++; $display("FAIL idle_defaults got=%0b%0b exp=10", hif.pc_write, hif.ifid_flush); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        hif.idex_is_load = 1'b1;
        hif.idex_rd      = 5'd5;
        hif.id_rs2       = 5'd5;
        hif.id_uses_rs2  = 1'b1;
        @(negedge clk);
        checks++; if (hif.pc_write !== 1'b0) begin failures++; $display("FAIL lu_pc_write got=%0b exp=0", hif.pc_write); end
        checks++; if (hif.ifid_write !== 1'b0) begin failures++; $display("FAIL lu_ifid_write got=%0b exp=0", hif.ifid_write); end
        checks++; if (hif.idex_bubble !== 1'b1) begin failures++; $display("FAIL lu_bubble got=%0b exp=1", hif.idex_bubble); end
        checks++; if (hif.pipe_freeze !== 1'b0 || hif.ifid_flush !== 1'b0) begin failures++; $display("FAIL lu_freeze_flush got=%0b%0b exp=00", hif.pipe_freeze, hif.ifid_flush); end
        tick();
        hif.idex_is_load = 1'b0;
        @(negedge clk);
        checks++; if (hif.pc_write !== 1'b1 || hif.ifid_write !== 1'b1 || hif.idex_bubble !== 1'b0) begin failures++; $display("FAIL lu_release got=%0b%0b%0b exp=110", hif.pc_write, hif.ifid_write, hif.idex_bubble); end
        checks++; if (stall_cycles !== 4'd1) begin failures++; $display("FAIL lu_stall got=%0d exp=1", stall_cycles); end
        checks++; if (hz_state !== 2'b00) begin failures++; $display("FAIL lu_state got=%0d exp=0", hz_state); end
        tick();
    endtask

    task automatic test_x0_unused();
        do_reset();
        hif.idex_is_load = 1'b1;
        hif.idex_rd      = 5'd0;
        hif.id_rs1       = 5'd0;
        hif.id_uses_rs1  = 1'b1;
        @(negedge clk);
        checks++; if (hif.pc_write !== 1'b1 || hif.idex_bubble !== 1'b0) begin failures++; $display("FAIL x0_no_stall got=%0b%0b exp=10", hif.pc_write, hif.idex_bubble); end
        tick();
        hif.idex_rd     = 5'd7;
        hif.id_rs1      = 5'd7;
        hif.id_uses_rs1 = 1'b0;
        @(negedge clk);
        checks++; if (hif.pc_write !== 1'b1 || hif.idex_bubble !== 1'b0) begin failures++; $display("FAIL unused_rs1 got=%0b%0b exp=10", hif.pc_write, hif.idex_bubble); end
        tick();
        hif.id_uses_rs1 = 1'b1;
        @(negedge clk);
        checks++; if (hif.pc_write !== 1'b0) begin failures++; $display("FAIL rs1_hit got=%0b exp=0", hif.pc_write); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (stall_cycles !== 4'd1) begin failures++; $display("FAIL x0_stall got=%0d exp=1", stall_cycles); end
        tick();
    endtask

    task automatic test_branch_over_load_use();
        do_reset();
        hif.idex_is_load    = 1'b1;
        hif.idex_rd         = 5'd9;
        hif.id_rs1          = 5'd9;
        hif.id_uses_rs1     = 1'b1;
        hif.ex_branch_taken = 1'b1;
        @(negedge clk);
        checks++; if (hif.ifid_flush !== 1'b1) begin failures++; $display("FAIL br_flush got=%0b exp=1", hif.ifid_flush); end
        checks++; if (hif.idex_bubble !== 1'b1) begin failures++; $display("FAIL br_bubble got=%0b exp=1", hif.idex_bubble); end
        checks++; if (hif.pc_write !== 1'b1 || hif.ifid_write !== 1'b1) begin failures++; $display("FAIL br_pc_write got=%0b%0b exp=11", hif.pc_write, hif.ifid_write); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (stall_cycles !== 4'd0) begin failures++; $display("FAIL br_stall got=%0d exp=0", stall_cycles); end
        tick();
    endtask

    task automatic test_mem_wait();
        do_reset();
        hif.mem_req   = 1'b1;
        hif.mem_ready = 1'b1;
        @(negedge clk);
        checks++; if (hif.pc_write !== 1'b1 || hif.pipe_freeze !== 1'b0) begin failures++; $display("FAIL hit_no_stall got=%0b%0b exp=10", hif.pc_write, hif.pipe_freeze); end
        tick();
        hif.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (hif.pipe_freeze !== 1'b1 || hif.pc_write !== 1'b0) begin failures++; $display("FAIL mw_freeze cyc=%0d got=%0b%0b exp=10", i, hif.pipe_freeze, hif.pc_write); end
            checks++; if (hz_state !== ((i == 0) ? 2'b00 : 2'b01)) begin failures++; $display("FAIL mw_state cyc=%0d got=%0d exp=%0d", i, hz_state, (i == 0) ? 0 : 1); end
            tick();
        end
        hif.mem_ready = 1'b1;
        @(negedge clk);
        checks++; if (hif.pipe_freeze !== 1'b0 || hif.pc_write !== 1'b1) begin failures++; $display("FAIL mw_release got=%0b%0b exp=01", hif.pipe_freeze, hif.pc_write); end
        checks++; if (hz_state !== 2'b01) begin failures++; $display("FAIL mw_release_state got=%0d exp=1", hz_state); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (hz_state !== 2'b00) begin failures++; $display("FAIL mw_back_run got=%0d exp=0", hz_state); end
        checks++; if (stall_cycles !== 4'd3) begin failures++; $display("FAIL mw_stall got=%0d exp=3", stall_cycles); end
        tick();
    endtask

    task automatic test_release_at_limit();
        do_reset();
        hif.mem_req = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        hif.mem_ready = 1'b1;
        @(negedge clk);
        checks++; if (hif.pc_write !== 1'b1 || hz_state !== 2'b01) begin failures++; $display("FAIL lim_release got=%0b/%0d exp=1/1", hif.pc_write, hz_state); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (hz_state !== 2'b00 || mem_timeout !== 1'b0) begin failures++; $display("FAIL lim_no_halt got=%0d/%0b exp=0/0", hz_state, mem_timeout); end
        checks++; if (stall_cycles !== 4'd4) begin failures++; $display("FAIL lim_stall got=%0d exp=4", stall_cycles); end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        hif.mem_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (hif.pipe_freeze !== 1'b1 || mem_timeout !== 1'b0) begin failures++; $display("FAIL to_frozen cyc=%0d got=%0b/%0b exp=1/0", i, hif.pipe_freeze, mem_timeout); end
            tick();
        end
        @(negedge clk);
        checks++; if (hz_state !== 2'b10) begin failures++; $display("FAIL to_state got=%0d exp=2", hz_state); end
        checks++; if (mem_timeout !== 1'b1) begin failures++; $display("FAIL to_flag got=%0b exp=1", mem_timeout); end
        checks++; if (stall_cycles !== 4'd5) begin failures++; $display("FAIL to_stall got=%0d exp=5", stall_cycles); end
        tick();
        hif.mem_ready = 1'b1;
        @(negedge clk);
        checks++; if (hz_state !== 2'b10 || hif.pc_write !== 1'b0) begin failures++; $display("FAIL halt_sticky got=%0d/%0b exp=2/0", hz_state, hif.pc_write); end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        checks++; if (hz_state !== 2'b00 || mem_timeout !== 1'b0 || stall_cycles !== 4'd0) begin failures++; $display("FAIL to_reset got=%0d/%0b/%0d exp=0/0/0", hz_state, mem_timeout, stall_cycles); end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        hif.mem_req = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 10) begin
                checks++; if (stall_cycles !== 4'hF) begin failures++; $display("FAIL sat_reach got=%0d exp=15", stall_cycles); end
            end
            tick();
        end
        @(negedge clk);
        checks++; if (stall_cycles !== 4'hF) begin failures++; $display("FAIL sat_hold got=%0d exp=15", stall_cycles); end
        checks++; if (hz_state !== 2'b10) begin failures++; $display("FAIL sat_state got=%0d exp=2", hz_state); end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        tick();
        test_reset();
        test_load_use();
        test_x0_unused();
        test_branch_over_load_use();
        test_mem_wait();
        test_release_at_limit();
        test_timeout();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
